// File: rtl/ie_input_conditioner.sv
// Input conditioner for the IE01/IE02 switch and button lines: 2-FF synchronizer plus
// stability-counter debounce per line, registered function words, press pulses and update strobe.

module ie_deb_line #(
   parameter int DEB_CYCLES = 500000,
   parameter int CNT_W      = 19
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;

   // Any agreement with the stable value restarts the count, so bounces never accumulate.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module ie_input_conditioner #(
   parameter int DEB_CYCLES     = 500000,
   parameter int CNT_W          = 19,
   parameter bit BTN_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ie01_sw,
   input  logic [1:0] ie01_btn,
   input  logic [3:0] ie02_sw,
   input  logic [1:0] ie02_btn,
   output logic [5:0] ie01_fn_q,
   output logic [5:0] ie02_fn_q,
   output logic [1:0] ie01_press,
   output logic [1:0] ie02_press,
   output logic       upd
);
   localparam int NUM_LANES = 12;
   // Button lanes sit in bits [7:6] and [1:0] of the lane vector.
   localparam logic [NUM_LANES-1:0] INV_MASK = BTN_ACTIVE_LOW ? 12'b000011_000011 : 12'b0;

   logic [NUM_LANES-1:0] raw, stable, stable_prev;

   assign raw = {ie01_sw, ie01_btn, ie02_sw, ie02_btn} ^ INV_MASK;

   generate
      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
         ie_deb_line #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
         ) u_line (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw[i]),
            .stable (stable[i])
         );
      end
   endgenerate

   assign ie01_fn_q = stable[11:6];
   assign ie02_fn_q = stable[5:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         stable_prev <= '0;
         ie01_press  <= 2'b00;
         ie02_press  <= 2'b00;
         upd         <= 1'b0;
      end else begin
         stable_prev <= stable;
         ie01_press  <= stable[7:6] & ~stable_prev[7:6];
         ie02_press  <= stable[1:0] & ~stable_prev[1:0];
         upd         <= |(stable ^ stable_prev);
      end
   end
endmodule

// File: tb/tb_ie_input_conditioner.sv
// Scoreboard bench for ie_input_conditioner: directed steps push expected upd/press events,
// a negedge monitor pops and compares whenever the DUT shows an upd or press pulse.
module tb_ie_input_conditioner;
   localparam int DEB = 4;
   localparam int CW  = 3;

   typedef struct {
      int         cyc;
      logic [5:0] f1;
      logic [5:0] f2;
      logic [1:0] p1;
      logic [1:0] p2;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst, rst2;
   logic [3:0] sw1, sw2, a_sw1, a_sw2;
   logic [1:0] bt1, bt2, a_bt1, a_bt2;
   logic [5:0] fn1, fn2, a_fn1, a_fn2;
   logic [1:0] pr1, pr2, a_pr1, a_pr2;
   logic       upd, a_upd;

   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   bit  mon_en = 1'b0;
   ev_t exp_q[$];
   ev_t e;
   logic [5:0] w1, w2;

   ie_input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(CW), .BTN_ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .rst(rst), .ie01_sw(sw1), .ie01_btn(bt1), .ie02_sw(sw2), .ie02_btn(bt2),
      .ie01_fn_q(fn1), .ie02_fn_q(fn2), .ie01_press(pr1), .ie02_press(pr2), .upd(upd));

   ie_input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(CW), .BTN_ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .rst(rst2), .ie01_sw(a_sw1), .ie01_btn(a_bt1), .ie02_sw(a_sw2), .ie02_btn(a_bt2),
      .ie01_fn_q(a_fn1), .ie02_fn_q(a_fn2), .ie01_press(a_pr1), .ie02_press(a_pr2), .upd(a_upd));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_ev(input int c, input logic [1:0] p1, input logic [1:0] p2);
      ev_t x;
      x.cyc = c; x.f1 = w1; x.f2 = w2; x.p1 = p1; x.p2 = p2;
      exp_q.push_back(x);
   endtask

   // Monitor: every upd/press pulse on the main DUT must match the next queued event exactly.
   always @(negedge clk) begin
      if (mon_en && (upd !== 1'b0 || pr1 !== 2'b00 || pr2 !== 2'b00)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: cyc %0d upd %b fn1 %b fn2 %b pr1 %b pr2 %b",
                     cyc, upd, fn1, fn2, pr1, pr2);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || upd !== 1'b1 || fn1 !== e.f1 || fn2 !== e.f2 ||
                pr1 !== e.p1 || pr2 !== e.p2) begin
               failures++;
               $display("FAIL event: got cyc %0d upd %b fn1 %b fn2 %b pr1 %b pr2 %b, expected cyc %0d upd 1 fn1 %b fn2 %b pr1 %b pr2 %b",
                        cyc, upd, fn1, fn2, pr1, pr2, e.cyc, e.f1, e.f2, e.p1, e.p2);
            end
         end
      end
   end

   initial begin
      int c;
      rst = 1'b1; rst2 = 1'b1;
      sw1 = 4'hF; bt1 = 2'b11; sw2 = 4'hF; bt2 = 2'b11;
      a_sw1 = 4'h0; a_bt1 = 2'b11; a_sw2 = 4'h0; a_bt2 = 2'b11;

      // 1: reset with all inputs high, then release
      @(negedge clk);
      mon_en = 1'b1;
      step(2);
      chk("rst_fn1", fn1, 6'h00);
      chk("rst_fn2", fn2, 6'h00);
      chk("rst_press", {pr1, pr2}, 4'h0);
      chk("rst_upd", upd, 1'b0);
      c = cyc; rst = 1'b0;
      w1 = 6'h3F; w2 = 6'h3F;
      push_ev(c + 7, 2'b11, 2'b11);
      step(5); chk("rst_release_early", {fn1, fn2}, 12'h000);
      step(1); chk("rst_release_fn", {fn1, fn2}, {w1, w2});
      step(4);
      c = cyc; sw1 = 4'h0; bt1 = 2'b00; sw2 = 4'h0; bt2 = 2'b00;
      w1 = 6'h00; w2 = 6'h00;
      push_ev(c + 7, 2'b00, 2'b00);
      step(10);
      chk("all_low", {fn1, fn2}, 12'h000);

      // 2: clean switch step
      c = cyc; sw1[3] = 1'b1; w1 = 6'b100000;
      push_ev(c + 7, 2'b00, 2'b00);
      step(5); chk("sw_early", fn1, 6'b000000);
      step(1); chk("sw_stable", fn1, w1);
      step(4);

      // 3: bounce on ie02_sw[0], never long enough to be accepted
      for (int i = 0; i < 6; i++) begin
         sw2[0] = (i % 2 == 0);
         step(1); chk("bounce_hold", fn2, w2);
         step(1); chk("bounce_hold", fn2, w2);
      end
      c = cyc; sw2[0] = 1'b1; w2[2] = 1'b1;
      push_ev(c + 7, 2'b00, 2'b00);
      step(5); chk("bounce_early", fn2[2], 1'b0);
      step(1); chk("bounce_stable", fn2, w2);
      step(4);

      // 4: button held 20 cycles, then released
      c = cyc; bt2[0] = 1'b1; w2[0] = 1'b1;
      push_ev(c + 7, 2'b00, 2'b01);
      step(6); chk("btn_level_hi", fn2[0], 1'b1);
      step(14);
      c = cyc; bt2[0] = 1'b0; w2[0] = 1'b0;
      push_ev(c + 7, 2'b00, 2'b00);
      step(6); chk("btn_level_lo", fn2[0], 1'b0);
      step(4);

      // 5: simultaneous events on both channels
      c = cyc; bt1[1] = 1'b1; sw2[2] = 1'b1; w1[1] = 1'b1; w2[4] = 1'b1;
      push_ev(c + 7, 2'b10, 2'b00);
      step(5); chk("simul_early", {fn1[1], fn2[4]}, 2'b00);
      step(1); chk("simul_fn", {fn1, fn2}, {w1, w2});
      step(4);

      // 6: active-low buttons, reset mid-count
      rst2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("al_idle", {a_fn1, a_fn2, a_pr1, a_pr2, a_upd}, 17'h0);
      end
      a_bt1[0] = 1'b0;
      step(3); rst2 = 1'b1;
      step(2); rst2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1); chk("al_after_rst_early", a_fn1, 6'h00);
      end
      step(1); chk("al_fn", a_fn1, 6'b000001);
      chk("al_press_early", a_pr1, 2'b00);
      step(1); chk("al_press", a_pr1, 2'b01);
      chk("al_upd", a_upd, 1'b1);
      step(1); chk("al_press_end", {a_pr1, a_upd}, 3'b000);

      step(2);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ie_input_conditioner.md
Name: ie_input_conditioner

Overview:
- Synchronous input-conditioning stage sitting directly upstream of the two seletorFUN instances.
- Takes the raw switches and push-buttons for IE01 and IE02 and runs each line through a 2-FF synchronizer and a stability-counter debouncer.
- Delivers clean, registered 6-bit function words in seletorFUN input order {CH_hi..CH_lo, B_hi, B_lo}.
- Also produces one-cycle button press pulses and a global update strobe for downstream logic.

Parameters:
- DEB_CYCLES, 500000, consecutive cycles a synchronized input must differ from its stable value before the stable value is updated (10 ms at 50 MHz).
- CNT_W, 19, width of each debounce counter; must satisfy 2^CNT_W > DEB_CYCLES.
- BTN_ACTIVE_LOW, 1, when 1 the four button inputs are inverted before synchronization (board buttons read 0 when pressed); switches are never inverted.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ie01_sw  input  4  raw IE01 switches {CH7,CH6,CH5,CH4}
- ie01_btn  input  2  raw IE01 buttons {B3,B2}
- ie02_sw  input  4  raw IE02 switches {CH3,CH2,CH1,CH0}
- ie02_btn  input  2  raw IE02 buttons {B1,B0}
- ie01_fn_q  output  6  debounced IE01 word {sw[3:0], btn[1:0]}, feeds seletorFUN IE01
- ie02_fn_q  output  6  debounced IE02 word, same ordering
- ie01_press  output  2  one-cycle pulse per IE01 button on debounced 0->1
- ie02_press  output  2  one-cycle pulse per IE02 button on debounced 0->1
- upd  output  1  one-cycle pulse when any bit of ie01_fn_q or ie02_fn_q changes

Behaviour:
- There is one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset: all synchronizer flops, stable registers, counters, edge-history flops and all outputs go to 0, including upd and the press pulses. Button inversion is applied before the synchronizers, so a released active-low button is already 0 and no spurious pulse appears after reset.
- Lines: 12 independent lines, 8 switches and 4 buttons. Each line has the same datapath:
  - stage s1 <= raw (optionally inverted)
  - stage s2 <= s1
  - counter and stable register as below.
- Debounce rule, per line, each cycle:
  - if s2 == stable: cnt <= 0
  - else if cnt == DEB_CYCLES-1: stable <= s2 and cnt <= 0
  - else: cnt <= cnt+1
- Counter behaviour: the counter never wraps. It is cleared on every agreement and on every update.
- Latency: a clean input step seen at clock edge k appears on the stable output at edge k+2+DEB_CYCLES. The same latency applies to rising and falling edges.
- Bounce rejection: any reversion of s2 to the stable value before the count completes restarts the count from 0. A glitch shorter than DEB_CYCLES therefore never reaches the outputs.
- Outputs: ie0x_fn_q is the stable registers directly, with no extra combinational logic.
- Press pulses:
  - press[i] = stable_btn[i] & ~stable_btn_prev[i], where stable_btn_prev is registered every cycle.
  - The pulse appears exactly one cycle after the stable bit rises and lasts exactly 1 cycle.
  - Release (1->0) produces no pulse.
- upd: registered OR over all 12 lines of (stable != stable_prev). It is asserted in the same cycle as the press pulses. Multiple lines changing in the same cycle produce a single 1-cycle upd.
- Channel independence: the two channels are fully independent, and simultaneous events on both complete in the same cycle.
- Reset mid-operation: counts in progress are discarded. After rst deasserts, a held input needs the full 2+DEB_CYCLES cycles again.
- Held button: a button held for any length of time gives exactly one pulse.

Test Plan:
All scenarios use DEB_CYCLES=4 and BTN_ACTIVE_LOW=0 unless stated.
1. Reset: hold rst with all raw inputs at 1 for 3 cycles -> ie01_fn_q=ie02_fn_q=6'b000000, press=0, upd=0. Release rst and hold inputs -> both words become 6'b111111 exactly 6 cycles later, with upd high for exactly 1 cycle one edge after that.
2. Clean switch: ie01_sw[3] 0->1 at edge k, held -> ie01_fn_q=6'b100000 at edge k+6 and no earlier. upd=1 at edge k+7 only. ie01_press stays 0.
3. Bounce: ie02_sw[0] toggles every 2 cycles for 12 cycles, then holds 1 from edge m -> ie02_fn_q[2] stays 0 throughout the bounce and rises at edge m+6. Exactly one upd pulse.
4. Button: ie02_btn[0] high for 20 cycles then low -> ie02_press[0] is a single 1-cycle pulse at input edge +7. ie02_fn_q[0] follows the level. No pulse on release.
5. Simultaneous: ie01_btn[1] and ie02_sw[2] rise on the same edge -> both stable bits update on the same edge, ie01_press[1] pulses, and upd is a single 1-cycle pulse.
6. Reset mid-count plus active-low: with BTN_ACTIVE_LOW=1, ie01_btn[0] driven 0 (pressed) and rst asserted 3 cycles after the input change -> after release the output rises only 6 cycles after rst deasserts. Idle-high buttons through reset give press=0.
